// File: rtl/scan_capture.sv
// scan_capture: receive-side monitor for the multiplexed seven-segment scan.
// Registers the scanned digit-select and segment buses, checks the 8-slot
// scan order and per-slot hold time, decodes each segment pattern to BCD and
// publishes all six digits together once a whole frame has been seen clean.
//
// Ports:
//   fs          system clock, all logic on posedge
//   rst         asynchronous reset, active-high
//   led_dig     digit select, active-low one-hot
//   display     segments {0,g,f,e,d,c,b,a}, active-high
//   a..f        decoded digits of slots 0,1,3,4,6,7
//   frame_valid one-cycle pulse when a..f update
//   locked      high after LOCK_FRAMES consecutive good frames
//   err         one-cycle pulse on any error
//   err_code    cause of the last error (1 select, 2 sequence, 3 pattern,
//               4 range, 5 timing), held until the next error
module scan_capture #(
    parameter int unsigned SLOT_CYCLES = 1,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       fs,
    input  logic       rst,
    input  logic [7:0] led_dig,
    input  logic [7:0] display,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] c,
    output logic [3:0] d,
    output logic [3:0] e,
    output logic [3:0] f,
    output logic       frame_valid,
    output logic       locked,
    output logic       err,
    output logic [2:0] err_code
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned GOOD_W = 4;
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SLOT_CYCLES);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_FRAMES);
    localparam logic [3:0] GLYPH_DASH = 4'hA;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_SEL   = 3'd1;
    localparam logic [2:0] ERR_SEQ   = 3'd2;
    localparam logic [2:0] ERR_PAT   = 3'd3;
    localparam logic [2:0] ERR_RANGE = 3'd4;
    localparam logic [2:0] ERR_TIME  = 3'd5;

    typedef enum logic [1:0] {ST_HUNT, ST_COLLECT, ST_DONE} state_e;

    // {valid, slot} from the active-low select
    function automatic logic [3:0] decode_sel(input logic [7:0] dig);
        logic [3:0] r;
        r = 4'b0000;
        case (dig)
            8'hEF:   r = {1'b1, 3'd0};
            8'hF7:   r = {1'b1, 3'd1};
            8'hFD:   r = {1'b1, 3'd2};
            8'hFE:   r = {1'b1, 3'd3};
            8'hFB:   r = {1'b1, 3'd4};
            8'h7F:   r = {1'b1, 3'd5};
            8'hBF:   r = {1'b1, 3'd6};
            8'hDF:   r = {1'b1, 3'd7};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // {valid, value}; value GLYPH_DASH marks the dash glyph
    function automatic logic [4:0] decode_seg(input logic [7:0] seg);
        logic [4:0] r;
        r = 5'b00000;
        case (seg)
            8'h3F:   r = {1'b1, 4'd0};
            8'h06:   r = {1'b1, 4'd1};
            8'h5B:   r = {1'b1, 4'd2};
            8'h4F:   r = {1'b1, 4'd3};
            8'h66:   r = {1'b1, 4'd4};
            8'h6D:   r = {1'b1, 4'd5};
            8'h7D:   r = {1'b1, 4'd6};
            8'h07:   r = {1'b1, 4'd7};
            8'h7F:   r = {1'b1, 4'd8};
            8'h6F:   r = {1'b1, 4'd9};
            8'h40:   r = {1'b1, GLYPH_DASH};
            default: r = 5'b00000;
        endcase
        return r;
    endfunction

    function automatic logic slot_is_dash(input logic [2:0] slot);
        return (slot == 3'd2) || (slot == 3'd5);
    endfunction

    function automatic logic [3:0] slot_max(input logic [2:0] slot);
        logic [3:0] r;
        case (slot)
            3'd4:    r = 4'd5;
            3'd7:    r = 4'd2;
            default: r = 4'd9;
        endcase
        return r;
    endfunction

    // digit slots 0,1,3,4,6,7 packed into shadow/output positions 0..5
    function automatic logic [2:0] shadow_idx(input logic [2:0] slot);
        logic [2:0] r;
        case (slot)
            3'd1:    r = 3'd1;
            3'd3:    r = 3'd2;
            3'd4:    r = 3'd3;
            3'd6:    r = 3'd4;
            3'd7:    r = 3'd5;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    logic [7:0]        dig_q, seg_q;
    state_e            state_q, state_d;
    logic [2:0]        slot_q, slot_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        hold_dig_q, hold_dig_d, hold_seg_q, hold_seg_d;
    logic [5:0][3:0]   shadow_q, shadow_d, digits_q, digits_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              locked_q, locked_d, frame_valid_q, frame_valid_d;
    logic              err_q, err_d;
    logic [2:0]        err_code_q, err_code_d;

    logic       sel_ok, seg_ok, seg_dash, start0, is_first, take_first;
    logic [2:0] sel_slot, exp_slot, code;
    logic [3:0] seg_val;

    assign {sel_ok, sel_slot} = decode_sel(dig_q);
    assign {seg_ok, seg_val}  = decode_seg(seg_q);
    assign seg_dash = (seg_val == GLYPH_DASH);
    // a clean first cycle of slot 0 can open a frame from any state
    assign start0 = sel_ok && (sel_slot == 3'd0) && seg_ok && !seg_dash;

    // classify the current registered sample against the expected position
    always_comb begin
        is_first = 1'b1;
        exp_slot = 3'd0;
        code     = ERR_NONE;
        if (state_q == ST_COLLECT) begin
            is_first = (cnt_q == SLOT_LAST);
            exp_slot = is_first ? 3'(slot_q + 3'd1) : slot_q;
        end
        if (is_first) begin
            if (!sel_ok)                                       code = ERR_SEL;
            else if (sel_slot != exp_slot)                     code = ERR_SEQ;
            else if (!seg_ok || (seg_dash != slot_is_dash(exp_slot))) code = ERR_PAT;
            else if (!seg_dash && (seg_val > slot_max(exp_slot)))     code = ERR_RANGE;
        end else if ((dig_q != hold_dig_q) || (seg_q != hold_seg_q)) begin
            if (!sel_ok)      code = ERR_SEL;
            else if (!seg_ok) code = ERR_PAT;
            else              code = ERR_TIME;
        end
    end

    // next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        cnt_d         = cnt_q;
        hold_dig_d    = hold_dig_q;
        hold_seg_d    = hold_seg_q;
        shadow_d      = shadow_q;
        digits_d      = digits_q;
        good_d        = good_q;
        locked_d      = locked_q;
        frame_valid_d = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        take_first    = 1'b0;

        if (state_q == ST_HUNT) begin
            take_first = start0;
        end else if (code != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = code;
            good_d     = '0;
            locked_d   = 1'b0;
            shadow_d   = '0;
            state_d    = ST_HUNT;
            take_first = start0;
        end else if (is_first) begin
            take_first = 1'b1;
        end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
        end

        if (take_first) begin
            state_d    = ST_COLLECT;
            slot_d     = sel_slot;
            cnt_d      = CNT_W'(1);
            hold_dig_d = dig_q;
            hold_seg_d = seg_q;
            if (!slot_is_dash(sel_slot)) begin
                shadow_d[shadow_idx(sel_slot)] = seg_val;
            end
        end

        // slot 7 has run its full length: publish the frame
        if ((state_d == ST_COLLECT) && (slot_d == 3'd7) && (cnt_d == SLOT_LAST)) begin
            state_d       = ST_DONE;
            digits_d      = shadow_d;
            frame_valid_d = 1'b1;
            good_d        = (good_q < GOOD_MAX) ? GOOD_W'(good_q + 1'b1) : good_q;
            locked_d      = (good_d >= GOOD_MAX);
        end
    end

    always_ff @(posedge fs or posedge rst) begin
        if (rst) begin
            dig_q         <= 8'hFF;
            seg_q         <= 8'h00;
            state_q       <= ST_HUNT;
            slot_q        <= 3'd0;
            cnt_q         <= '0;
            hold_dig_q    <= 8'hFF;
            hold_seg_q    <= 8'h00;
            shadow_q      <= '0;
            digits_q      <= '0;
            good_q        <= '0;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            dig_q         <= led_dig;
            seg_q         <= display;
            state_q       <= state_d;
            slot_q        <= slot_d;
            cnt_q         <= cnt_d;
            hold_dig_q    <= hold_dig_d;
            hold_seg_q    <= hold_seg_d;
            shadow_q      <= shadow_d;
            digits_q      <= digits_d;
            good_q        <= good_d;
            locked_q      <= locked_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign a           = digits_q[0];
    assign b           = digits_q[1];
    assign c           = digits_q[2];
    assign d           = digits_q[3];
    assign e           = digits_q[4];
    assign f           = digits_q[5];
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_scan_capture.sv
// tb_scan_capture: drives scan streams into two scan_capture instances
// (hold 1 and hold 2 cycles per slot) and compares every output on every
// cycle with a frame-position reference model.
module tb_scan_capture;

    localparam int unsigned LF = 2;

    logic       fs = 1'b0;
    logic       rst;
    logic [7:0] ld1, ds1, ld2, ds2;
    logic [3:0] a1, b1, c1, d1, e1, f1, a2, b2, c2, d2, e2, f2;
    logic       fv1, lk1, er1, fv2, lk2, er2;
    logic [2:0] ec1, ec2;

    always #5 fs = ~fs;

    scan_capture #(.SLOT_CYCLES(1), .LOCK_FRAMES(LF)) u_dut1 (
        .fs(fs), .rst(rst), .led_dig(ld1), .display(ds1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1),
        .frame_valid(fv1), .locked(lk1), .err(er1), .err_code(ec1)
    );

    scan_capture #(.SLOT_CYCLES(2), .LOCK_FRAMES(LF)) u_dut2 (
        .fs(fs), .rst(rst), .led_dig(ld2), .display(ds2),
        .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2),
        .frame_valid(fv2), .locked(lk2), .err(er2), .err_code(ec2)
    );

    int act;
    int m_sc;
    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] ga, gb, gc, gd, ge, gf;
    logic       gfv, glk, ger;
    logic [2:0] gec;
    assign ga  = (act == 1) ? a1  : a2;
    assign gb  = (act == 1) ? b1  : b2;
    assign gc  = (act == 1) ? c1  : c2;
    assign gd  = (act == 1) ? d1  : d2;
    assign ge  = (act == 1) ? e1  : e2;
    assign gf  = (act == 1) ? f1  : f2;
    assign gfv = (act == 1) ? fv1 : fv2;
    assign glk = (act == 1) ? lk1 : lk2;
    assign ger = (act == 1) ? er1 : er2;
    assign gec = (act == 1) ? ec1 : ec2;

    logic [7:0] sel_tab [8] = '{8'hEF, 8'hF7, 8'hFD, 8'hFE, 8'hFB, 8'h7F, 8'hBF, 8'hDF};
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // reference model: position within the frame, -1 while hunting
    int         m_pos;
    int         m_sh [8];
    int         m_out [6];
    int         m_code, m_good;
    bit         m_fv, m_err, m_lock;
    logic [7:0] m_rdig, m_rseg, m_hd, m_hs;

    int fd [8];
    int n_fv;
    int lock_at [8];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sel_of(input logic [7:0] dig);
        for (int i = 0; i < 8; i++) if (dig == sel_tab[i]) return i;
        return -1;
    endfunction

    function automatic int glyph_of(input logic [7:0] seg);
        if (seg[7]) return -1;
        for (int i = 0; i < 10; i++) if (seg[6:0] == seg_tab[i]) return i;
        if (seg == 8'h40) return 10;
        return -1;
    endfunction

    function automatic int slot_lim(input int s);
        if (s == 4) return 5;
        if (s == 7) return 2;
        return 9;
    endfunction

    function automatic logic [7:0] seg_of_glyph(input int g);
        if (g == 10) return 8'h40;
        return {1'b0, seg_tab[g]};
    endfunction

    task automatic model_reset();
        m_pos = -1; m_code = 0; m_good = 0;
        m_fv = 0; m_err = 0; m_lock = 0;
        m_rdig = 8'hFF; m_rseg = 8'h00;
        for (int i = 0; i < 6; i++) m_out[i] = 0;
    endtask

    task automatic model_start(input int s, input int g);
        if (s == 0 && g >= 0 && g <= 9) begin
            m_sh[0] = g; m_hd = m_rdig; m_hs = m_rseg; m_pos = 1;
        end else begin
            m_pos = -1;
        end
    endtask

    task automatic model_step();
        int s, g, exp_s, code;
        bit first;
        s = sel_of(m_rdig);
        g = glyph_of(m_rseg);
        m_fv = 0; m_err = 0; code = 0;
        if (m_pos < 0) begin
            model_start(s, g);
        end else begin
            exp_s = m_pos / m_sc;
            first = (m_pos % m_sc) == 0;
            if (first) begin
                if (s < 0) code = 1;
                else if (s != exp_s) code = 2;
                else if (g < 0 || ((g == 10) != (s == 2 || s == 5))) code = 3;
                else if (g != 10 && g > slot_lim(s)) code = 4;
            end else if (m_rdig != m_hd || m_rseg != m_hs) begin
                if (s < 0) code = 1;
                else if (g < 0) code = 3;
                else code = 5;
            end
            if (code != 0) begin
                m_err = 1; m_code = code; m_good = 0; m_lock = 0;
                model_start(s, g);
            end else begin
                if (first) begin
                    m_sh[s] = g; m_hd = m_rdig; m_hs = m_rseg;
                end
                m_pos++;
                if (m_pos == 8 * m_sc) begin
                    m_pos = 0;
                    m_out = '{m_sh[0], m_sh[1], m_sh[3], m_sh[4], m_sh[6], m_sh[7]};
                    m_fv = 1;
                    if (m_good < LF) m_good++;
                    m_lock = (m_good >= LF);
                end
            end
        end
    endtask

    task automatic check_outs();
        chk("a", int'(ga), m_out[0]);
        chk("b", int'(gb), m_out[1]);
        chk("c", int'(gc), m_out[2]);
        chk("d", int'(gd), m_out[3]);
        chk("e", int'(ge), m_out[4]);
        chk("f", int'(gf), m_out[5]);
        chk("frame_valid", int'(gfv), int'(m_fv));
        chk("err", int'(ger), int'(m_err));
        chk("err_code", int'(gec), m_code);
        chk("locked", int'(glk), int'(m_lock));
    endtask

    task automatic cyc(input logic [7:0] dg, input logic [7:0] sg);
        if (act == 1) begin
            ld1 = dg; ds1 = sg; ld2 = 8'hFF; ds2 = 8'h00;
        end else begin
            ld2 = dg; ds2 = sg; ld1 = 8'hFF; ds1 = 8'h00;
        end
        @(posedge fs);
        model_step();
        m_rdig = dg;
        m_rseg = sg;
        #1;
        check_outs();
        if (gfv) begin
            if (n_fv < 8) lock_at[n_fv] = int'(glk);
            n_fv++;
        end
    endtask

    task automatic set_digits(input int da, input int db, input int dc,
                              input int dd, input int de, input int df);
        fd = '{da, db, 10, dc, dd, 10, de, df};
    endtask

    task automatic send_slot(input int s, input logic [7:0] sg);
        repeat (m_sc) cyc(sel_tab[s], sg);
    endtask

    task automatic send_frame();
        for (int s = 0; s < 8; s++) send_slot(s, seg_of_glyph(fd[s]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge fs);
        #1;
        check_outs();
        rst = 1'b0;
    endtask

    task automatic rand_frame();
        int fault_at, kind, idx;
        logic [7:0] dg, sg;
        set_digits(int'($urandom_range(9)), int'($urandom_range(9)), int'($urandom_range(9)),
                   int'($urandom_range(5)), int'($urandom_range(9)), int'($urandom_range(2)));
        fault_at = ($urandom_range(4) == 0) ? int'($urandom_range(8 * m_sc - 1)) : -1;
        kind = int'($urandom_range(4));
        idx = 0;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < m_sc; k++) begin
                dg = sel_tab[s];
                sg = seg_of_glyph(fd[s]);
                if (idx == fault_at) begin
                    case (kind)
                        0: dg = 8'($urandom);
                        1: sg = 8'($urandom);
                        2: dg = sel_tab[$urandom_range(7)];
                        4: sg = seg_of_glyph(int'($urandom_range(9)));
                        default: ;
                    endcase
                end
                if (!(idx == fault_at && kind == 3)) cyc(dg, sg);
                idx++;
            end
        end
        if ($urandom_range(9) == 0) repeat ($urandom_range(3, 1)) cyc(8'hFF, 8'h00);
    endtask

    initial begin
        int fv_base;
        act = 1; m_sc = 1; n_fv = 0;
        ld1 = 8'hFF; ds1 = 8'h00; ld2 = 8'hFF; ds2 = 8'h00;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge fs);
        #1;
        check_outs();
        rst = 1'b0;

        // three good frames, then a locked stream broken by slot 6 in slot 4
        set_digits(3, 7, 9, 5, 2, 1);
        repeat (3) send_frame();
        for (int s = 0; s < 8; s++) begin
            if (s == 4) send_slot(6, seg_of_glyph(fd[6]));
            else send_slot(s, seg_of_glyph(fd[s]));
        end
        chk("frames_1to3", n_fv, 3);
        chk("lock_fv1", lock_at[0], 0);
        chk("lock_fv2", lock_at[1], 1);
        chk("lock_fv3", lock_at[2], 1);
        chk("seq_code", int'(gec), 2);
        chk("seq_unlock", int'(glk), 0);
        chk("hold_a", int'(ga), 3);
        chk("hold_c", int'(gc), 9);
        chk("hold_f", int'(gf), 1);

        // recovery frame, then three content faults
        set_digits(4, 0, 1, 2, 3, 0);
        send_frame();
        for (int s = 0; s < 8; s++)
            send_slot(s, (s == 3) ? 8'h00 : seg_of_glyph(fd[s]));
        chk("recover_fv", n_fv, 4);
        chk("recover_a", int'(ga), 4);
        chk("blank_code", int'(gec), 3);
        for (int s = 0; s < 8; s++)
            send_slot(s, (s == 4) ? seg_of_glyph(7) : seg_of_glyph(fd[s]));
        chk("range_code", int'(gec), 4);
        for (int s = 0; s < 8; s++)
            send_slot(s, (s == 2) ? seg_of_glyph(0) : seg_of_glyph(fd[s]));
        chk("dash_code", int'(gec), 3);

        // two-cycle slots: short hold, bad select, reset mid-frame
        act = 2; m_sc = 2; n_fv = 0;
        do_reset();
        set_digits(1, 2, 3, 4, 5, 0);
        send_frame();
        for (int s = 0; s < 8; s++) begin
            if (s == 1) cyc(sel_tab[1], seg_of_glyph(fd[1]));
            else send_slot(s, seg_of_glyph(fd[s]));
        end
        chk("short_fv", n_fv, 1);
        chk("time_code", int'(gec), 5);
        for (int s = 0; s < 8; s++) begin
            if (s == 3) repeat (m_sc) cyc(8'hE7, seg_of_glyph(fd[3]));
            else send_slot(s, seg_of_glyph(fd[s]));
        end
        chk("sel_code", int'(gec), 1);
        send_frame();
        for (int s = 0; s < 5; s++) send_slot(s, seg_of_glyph(fd[s]));
        cyc(sel_tab[5], 8'h40);
        chk("pre_rst_a", int'(ga), 1);
        rst = 1'b1;
        #2;
        chk("rst_a", int'(ga), 0);
        chk("rst_e", int'(ge), 0);
        chk("rst_code", int'(gec), 0);
        chk("rst_fv", int'(gfv), 0);
        #2;
        rst = 1'b0;
        model_reset();
        cyc(sel_tab[5], 8'h40);
        send_slot(6, seg_of_glyph(fd[6]));
        send_slot(7, seg_of_glyph(fd[7]));
        fv_base = n_fv;
        set_digits(6, 8, 2, 0, 9, 2);
        repeat (2) send_frame();
        cyc(sel_tab[0], seg_of_glyph(fd[0]));
        chk("resume_fv", n_fv - fv_base, 2);
        chk("resume_b", int'(gb), 8);
        chk("resume_f", int'(gf), 2);

        // randomized frames with occasional faults on both instances
        for (int w = 1; w <= 2; w++) begin
            act = w; m_sc = w;
            do_reset();
            repeat (150) rand_frame();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
